multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main control FSM of the multicycle MIPS-subset processor.
//  Decodes opcode/funct from the instruction register and drives the datapath
//  selects, register/memory enables and the 3-bit ALU func code, one phase
//  per clock. Sits beside the datapath. Waits on a memory ready handshake.
// PARAMETERS
//  (none; encodings fixed by ISA subset)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous reset, active-high
//  opcode      in   6  IR[31:26]
//  funct       in   6  IR[5:0]
//  mem_ready   in   1  memory completes the current access this cycle
//  pc_write    out  1  unconditional PC load
//  pc_wr_cond  out  1  PC load if branch condition holds (datapath evaluates zero)
//  branch_ne   out  1  condition polarity: 0=beq (zero), 1=bne (!zero)
//  i_or_d      out  1  mem address: 0=PC, 1=ALUOut
//  mem_read    out  1  memory read request
//  mem_write   out  1  memory write request
//  ir_write    out  1  IR load
//  mem_to_reg  out  1  RF write data: 0=ALUOut, 1=MDR
//  reg_dst     out  1  RF dest: 0=rt, 1=rd
//  reg_write   out  1  RF write enable
//  alu_src_a   out  1  0=PC, 1=A
//  alu_src_b   out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  pc_source   out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alu_func    out  3  000 add,001 sub,010 and,011 or,100 xor,101 nor,110 sll,111 srl
//  illegal     out  1  one-cycle pulse: unsupported opcode/funct decoded
// BEHAVIOUR
//  - Reset: state<=FETCH. While rst=1 every output is 0. First FETCH follows rst deassert.
//  - States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_func=000.
//    Stays in FETCH while mem_ready=0 with ir_write=0 and pc_write=0.
//    When mem_ready=1: ir_write=1, pc_write=1, pc_source=00, next state DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_func=000 (branch target precompute). Next state by opcode:
//    0x00 -> EXEC_R if funct in {20,22,24,25,26,27,00,02}, else illegal=1 -> FETCH;
//    0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; other -> illegal=1 -> FETCH.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, func 000. Next MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD: mem_read=1, i_or_d=1. Held until mem_ready=1, then MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
//  - MEM_WR: mem_write=1, i_or_d=1. Held until mem_ready=1, then FETCH.
//  - EXEC_R: alu_src_a=1, alu_src_b=00. alu_func comes from funct:
//    20->000, 22->001, 24->010, 25->011, 26->100, 27->101, 00->110, 02->111.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. alu_func holds the EXEC_R value. Next FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, func 001, pc_wr_cond=1, pc_source=01,
//    branch_ne=(opcode==0x05). Next FETCH.
//  - JUMP: pc_write=1, pc_source=10. Next FETCH.
//  - Any output not listed for a state is 0. Outputs are combinational from state, opcode, funct and mem_ready.
//  - Cycles with mem_ready always 1: R=4, lw=5, sw=4, beq/bne=3, j=3. Each wait cycle adds 1.
//  - opcode/funct are sampled only in DECODE/EXEC_R/R_WB/MEM_ADDR/BRANCH. IR is stable there because ir_write=0.
//  - rst during any state, including a held memory wait: next state FETCH; the pending access is abandoned.
//  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
//  - An illegal pulse costs one DECODE cycle. The PC has already advanced by 4.
// CONFIGURATION
//  MC_IMM_OPS_EN defined: opcodes 0x08 addi, 0x0C andi, 0x0D ori, 0x0E xori are legal.
//    They go DECODE->EXEC_I->I_WB. EXEC_I: alu_src_a=1, alu_src_b=10,
//    func 000/010/011/100 respectively. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, func held. Total 4 cycles.
//    Note: andi/ori/xori use the sign-extended immediate (datapath has no zero-ext path).
//  MC_IMM_OPS_EN undefined: these opcodes pulse illegal and return to FETCH. States EXEC_I and I_WB do not exist.
// TESTING
//  1. rst=1 for 2 cycles, then released -> all outputs 0 during reset. Cycle 1 after release: FETCH with mem_read=1.
//  2. add (op 00, funct 20), mem_ready=1 -> FETCH,DECODE,EXEC_R(func 000),R_WB(reg_write=1, reg_dst=1). Back in FETCH in cycle 5.
//  3. lw (op 23) with mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles.
//     Exactly one MEM_WB with mem_to_reg=1. 8 cycles total.
//  4. bne (op 05) -> BRANCH: pc_wr_cond=1, branch_ne=1, func 001, pc_source=01. sll (funct 00) -> EXEC_R func 110.
//  5. op 3F -> illegal=1 for exactly one cycle, in DECODE. Next state FETCH; no reg_write/mem_write issued.
//  6. rst asserted mid MEM_WR wait -> mem_write=0 next cycle, then FETCH. With MC_IMM_OPS_EN: ori (op 0D) -> func 011, I_WB reg_dst=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset core: one datapath phase per clock.
// Define MC_IMM_OPS_EN to add addi/andi/ori/xori via the EXEC_I/I_WB states.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_wr_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_func,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    R_WB,
    BRANCH,
`ifdef MC_IMM_OPS_EN
    EXEC_I,
    I_WB,
`endif
    JUMP
  } state_t;

  state_t state, next;

  logic       r_ok;
  logic [2:0] r_func;

  always_comb begin
    r_ok   = 1'b1;
    r_func = 3'b000;
    case (funct)
      6'h20:   r_func = 3'b000;
      6'h22:   r_func = 3'b001;
      6'h24:   r_func = 3'b010;
      6'h25:   r_func = 3'b011;
      6'h26:   r_func = 3'b100;
      6'h27:   r_func = 3'b101;
      6'h00:   r_func = 3'b110;
      6'h02:   r_func = 3'b111;
      default: r_ok   = 1'b0;
    endcase
  end

`ifdef MC_IMM_OPS_EN
  logic       i_ok;
  logic [2:0] i_func;

  always_comb begin
    i_ok   = 1'b1;
    i_func = 3'b000;
    case (opcode)
      6'h08:   i_func = 3'b000;
      6'h0C:   i_func = 3'b010;
      6'h0D:   i_func = 3'b011;
      6'h0E:   i_func = 3'b100;
      default: i_ok   = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    pc_write   = 1'b0;
    pc_wr_cond = 1'b0;
    branch_ne  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_func   = 3'b000;
    illegal    = 1'b0;
    // Reset forces every control line low regardless of state.
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            next     = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          next      = FETCH;
          unique case (1'b1)
            opcode == 6'h00:
              if (r_ok) next = EXEC_R;
              else      illegal = 1'b1;
            opcode == 6'h23,
            opcode == 6'h2B: next = MEM_ADDR;
            opcode == 6'h04,
            opcode == 6'h05: next = BRANCH;
            opcode == 6'h02: next = JUMP;
`ifdef MC_IMM_OPS_EN
            i_ok:            next = EXEC_I;
`endif
            default:         illegal = 1'b1;
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          next      = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) next = MEM_WB;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          next       = FETCH;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) next = FETCH;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_func  = r_func;
          next      = R_WB;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          alu_func  = r_func;
          next      = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_func   = 3'b001;
          pc_wr_cond = 1'b1;
          pc_source  = 2'b01;
          branch_ne  = (opcode == 6'h05);
          next       = FETCH;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          next      = FETCH;
        end
`ifdef MC_IMM_OPS_EN
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_func  = i_func;
          next      = I_WB;
        end
        I_WB: begin
          reg_write = 1'b1;
          alu_func  = i_func;
          next      = FETCH;
        end
`endif
        default: next = FETCH;
      endcase
    end
  end

endmodule
